// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: autonomous conv-core sequencer. Walks every kernel position through
// weight/activation load, execute and psum drain, then runs the psum accumulation pass.
module core_seq_ctrl #(
  parameter int COL     = 8,
  parameter int ROW     = 8,
  parameter int IN_W    = 6,
  parameter int K_W     = 3,
  parameter int W_BASE  = 1024,
  parameter int RST_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx
);
  localparam int LEN_NIJ = IN_W*IN_W;
  localparam int LEN_KIJ = K_W*K_W;
  localparam int OUT_W   = IN_W-K_W+1;
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  typedef enum logic [4:0] {
    S_IDLE, S_KRST, S_G1, S_WFIFO, S_G2, S_KLOAD, S_KDRAIN, S_L0WR, S_G3,
    S_EXEC, S_G4, S_OFRD, S_G5, S_ARST, S_ARD, S_AGAP, S_DONE
  } state_t;

  state_t      r_state, w_state, w_nxt;
  logic [6:0]  r_cnt, w_cnt, w_len;
  logic [3:0]  r_kij, w_kij, r_oi, w_oi, r_oj, w_oj, r_ki, w_ki, r_kj, w_kj;
  logic [11:0] w_xa, w_pa;
  logic [33:0] w_inst, r_inst;
  logic        w_adv, w_crst, w_busy, w_done;
  logic        r_crst, r_busy, r_done;
  logic [3:0]  r_kij_o;

  // Outputs are decoded from the current state and registered, so every phase
  // becomes visible on the cycle after the state is entered.
  always_comb begin
    w_state = r_state;
    w_nxt   = r_state;
    w_cnt   = r_cnt + 7'd1;
    w_len   = 7'd1;
    w_adv   = 1'b1;
    w_kij   = r_kij;
    w_oi    = r_oi;
    w_oj    = r_oj;
    w_ki    = r_ki;
    w_kj    = r_kj;
    w_xa    = '0;
    w_pa    = '0;
    w_inst  = IDLE_WORD;
    w_crst  = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_adv  = 1'b0;
        w_busy = 1'b0;
        w_cnt  = '0;
        if (start) begin
          w_state = S_KRST;
          w_kij   = '0;
        end
      end
      S_KRST: begin w_len = 7'(RST_CYC); w_nxt = S_G1; w_crst = 1'b1; end
      S_G1:   w_nxt = S_WFIFO;
      S_WFIFO: begin
        w_len      = 7'(COL+1);
        w_nxt      = S_G2;
        w_xa       = 12'(W_BASE) + 12'(r_kij)*12'(COL) + 12'(r_cnt);
        w_inst[5]  = 1'b1;
        w_inst[19] = 1'b0;
      end
      S_G2:   w_nxt = S_KLOAD;
      S_KLOAD: begin w_len = 7'(COL); w_nxt = S_KDRAIN; w_inst[4] = 1'b1; w_inst[0] = 1'b1; end
      S_KDRAIN: begin w_len = 7'(ROW+COL+1); w_nxt = S_L0WR; w_inst[0] = 1'b1; end
      S_L0WR: begin
        w_len      = 7'(LEN_NIJ+1);
        w_nxt      = S_G3;
        w_xa       = 12'(r_cnt);
        w_inst[2]  = 1'b1;
        w_inst[19] = 1'b0;
      end
      S_G3:   w_nxt = S_EXEC;
      S_EXEC: begin w_len = 7'(LEN_NIJ+ROW+COL); w_nxt = S_G4; w_inst[3] = 1'b1; w_inst[1] = 1'b1; end
      S_G4:   w_nxt = S_OFRD;
      S_OFRD: begin
        // Stalls indefinitely on an empty ofifo; the count only moves on accepted words.
        w_adv = 1'b0;
        w_cnt = r_cnt;
        if (ofifo_valid) begin
          w_pa       = 12'(r_kij)*12'(LEN_NIJ) + 12'(r_cnt);
          w_inst[6]  = 1'b1;
          w_inst[32] = 1'b0;
          w_inst[31] = 1'b0;
          if (r_cnt == 7'(LEN_NIJ-1)) begin
            w_state = S_G5;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + 7'd1;
          end
        end
      end
      S_G5: begin
        if (r_kij == 4'(LEN_KIJ-1)) begin
          w_nxt = S_ARST;
          w_oi  = '0;
          w_oj  = '0;
        end else begin
          w_nxt = S_KRST;
          w_kij = r_kij + 4'd1;
        end
      end
      S_ARST: begin w_nxt = S_ARD; w_crst = 1'b1; w_ki = '0; w_kj = '0; end
      S_ARD: begin
        w_len      = 7'(LEN_KIJ+1);
        w_nxt      = S_AGAP;
        w_inst[33] = (r_cnt != '0);
        if (r_cnt < 7'(LEN_KIJ)) begin
          w_pa = 12'(r_cnt)*12'(LEN_NIJ) + (12'(r_oi) + 12'(r_ki))*12'(IN_W)
               + 12'(r_oj) + 12'(r_kj);
          w_inst[32] = 1'b0;
          if (r_kj == 4'(K_W-1)) begin
            w_kj = '0;
            w_ki = r_ki + 4'd1;
          end else begin
            w_kj = r_kj + 4'd1;
          end
        end
      end
      S_AGAP: begin
        if (r_oi == 4'(OUT_W-1) && r_oj == 4'(OUT_W-1)) begin
          w_nxt = S_DONE;
          w_oi  = '0;
          w_oj  = '0;
        end else begin
          w_nxt = S_ARST;
          if (r_oj == 4'(OUT_W-1)) begin
            w_oj = '0;
            w_oi = r_oi + 4'd1;
          end else begin
            w_oj = r_oj + 4'd1;
          end
        end
      end
      S_DONE: begin
        w_adv   = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_IDLE;
        w_cnt   = '0;
        w_kij   = '0;
      end
      default: begin w_adv = 1'b0; w_state = S_IDLE; w_cnt = '0; end
    endcase
    w_inst[17:7]  = w_xa[10:0];
    w_inst[30:20] = w_pa[10:0];
    if (w_adv && r_cnt == w_len - 7'd1) begin
      w_state = w_nxt;
      w_cnt   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_kij   <= '0;
      r_oi    <= '0;
      r_oj    <= '0;
      r_ki    <= '0;
      r_kj    <= '0;
      r_inst  <= IDLE_WORD;
      r_crst  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_kij_o <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_kij   <= w_kij;
      r_oi    <= w_oi;
      r_oj    <= w_oj;
      r_ki    <= w_ki;
      r_kj    <= w_kj;
      r_inst  <= w_inst;
      r_crst  <= w_crst;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_kij_o <= r_kij;
    end
  end

  a_addr_rng: assert property (@(posedge clk) disable iff (!reset) !w_xa[11] && !w_pa[11]);

  assign inst       = r_inst;
  assign core_reset = r_crst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign kij_idx    = r_kij_o;
endmodule
